// File: rtl/data_mem_resp.sv
// Single-port data memory answering core LSU accesses, plus a low-priority loader port, range errors and access counters.
// Both ports answer one cycle after acceptance; the core is never stalled, and the loader waits for a core-idle cycle.
module data_mem_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h0010_0000,
    parameter int          DEPTH_WORDS = 4096,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          data_mem_req_i,
    input  logic [31:0]   data_mem_addr_i,
    input  logic          data_mem_we_i,
    input  logic [3:0]    data_mem_be_i,
    input  logic [31:0]   data_mem_wdata_i,
    output logic          data_mem_rvalid_o,
    output logic [31:0]   data_mem_rdata_o,
    output logic          data_mem_err_o,
    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_wdata_i,
    output logic          ld_gnt_o,
    output logic          ld_rvalid_o,
    output logic [31:0]   ld_rdata_o,
    output logic          err_sticky_o,
    output logic [31:0]   err_addr_o,
    output logic [31:0]   rd_count_o,
    output logic [31:0]   wr_count_o
);

    // 33-bit bounds so that a window ending at 4 GiB does not wrap to zero.
    localparam logic [32:0] RANGE_LO = {1'b0, ADDR_BASE};
    localparam logic [32:0] RANGE_HI = RANGE_LO + (33'(DEPTH_WORDS) << 2);

    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          r_dm_rvalid;
    logic [31:0]   r_dm_rdata;
    logic          r_dm_err;
    logic          r_ld_rvalid;
    logic [31:0]   r_ld_rdata;
    logic          r_err_sticky;
    logic [31:0]   r_err_addr;
    logic [31:0]   r_rd_count;
    logic [31:0]   r_wr_count;

    logic [32:0]   w_addr_ext;
    logic          w_in_range;
    logic [31:0]   w_offset;
    logic [AW-1:0] w_core_idx;
    logic          w_core_wr;
    logic          w_core_rd;
    logic          w_core_oor;
    logic          w_ld_gnt;
    logic          w_ld_wr;
    logic          w_unused;

    assign w_addr_ext = {1'b0, data_mem_addr_i};
    assign w_in_range = (w_addr_ext >= RANGE_LO) && (w_addr_ext < RANGE_HI);
    assign w_offset   = data_mem_addr_i - ADDR_BASE;
    assign w_core_idx = w_offset[AW+1:2];

    // Byte-lane bits and the high offset bits above the word index carry no information here.
    assign w_unused   = &{1'b0, w_offset[31:AW+2], w_offset[1:0]};

    assign w_core_wr  = data_mem_req_i &  data_mem_we_i & w_in_range;
    assign w_core_rd  = data_mem_req_i & ~data_mem_we_i & w_in_range;
    assign w_core_oor = data_mem_req_i & ~w_in_range;

    assign w_ld_gnt   = ld_req_i & ~data_mem_req_i;
    assign w_ld_wr    = w_ld_gnt & ld_we_i;

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_core_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_mem_be_i[b]) begin
                    r_mem[w_core_idx][8*b +: 8] <= data_mem_wdata_i[8*b +: 8];
                end
            end
        end else if (w_ld_wr) begin
            r_mem[ld_addr_i] <= ld_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= 32'h0;
            r_dm_err    <= 1'b0;
        end else begin
            r_dm_rvalid <= data_mem_req_i;
            if (w_core_oor) begin
                r_dm_rdata <= 32'h0;
                r_dm_err   <= 1'b1;
            end else if (w_core_wr) begin
                r_dm_rdata <= 32'h0;
                r_dm_err   <= 1'b0;
            end else if (w_core_rd) begin
                r_dm_rdata <= r_mem[w_core_idx];
                r_dm_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_rvalid <= 1'b0;
            r_ld_rdata  <= 32'h0;
        end else begin
            r_ld_rvalid <= w_ld_gnt;
            if (w_ld_gnt) begin
                r_ld_rdata <= ld_we_i ? 32'h0 : r_mem[ld_addr_i];
            end
        end
    end

    // Only the first out-of-range address is kept; later errors leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_addr   <= 32'h0;
        end else if (w_core_oor && !r_err_sticky) begin
            r_err_sticky <= 1'b1;
            r_err_addr   <= data_mem_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= 32'h0;
            r_wr_count <= 32'h0;
        end else begin
            if (w_core_rd) r_rd_count <= r_rd_count + 32'd1;
            if (w_core_wr) r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign data_mem_rvalid_o = r_dm_rvalid;
    assign data_mem_rdata_o  = r_dm_rdata;
    assign data_mem_err_o    = r_dm_err;
    assign ld_gnt_o          = w_ld_gnt;
    assign ld_rvalid_o       = r_ld_rvalid;
    assign ld_rdata_o        = r_ld_rdata;
    assign err_sticky_o      = r_err_sticky;
    assign err_addr_o        = r_err_addr;
    assign rd_count_o        = r_rd_count;
    assign wr_count_o        = r_wr_count;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: stimulus pushes expected responses, a negedge monitor pops and compares them.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dm_req = 1'b0;
    logic [31:0] dm_addr = 32'h0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = 4'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        ld_req = 1'b0;
    logic        ld_we = 1'b0;
    logic [11:0] ld_addr = 12'h0;
    logic [31:0] ld_wdata = 32'h0;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        err_sticky;
    logic [31:0] err_addr;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } dm_exp_t;

    dm_exp_t     q_dm [$];
    logic [31:0] q_ld [$];
    int          n_vec = 0;
    int          n_miss = 0;

    data_mem_resp #(.ADDR_BASE(32'h0010_0000), .DEPTH_WORDS(4096)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_mem_req_i   (dm_req),
        .data_mem_addr_i  (dm_addr),
        .data_mem_we_i    (dm_we),
        .data_mem_be_i    (dm_be),
        .data_mem_wdata_i (dm_wdata),
        .data_mem_rvalid_o(dm_rvalid),
        .data_mem_rdata_o (dm_rdata),
        .data_mem_err_o   (dm_err),
        .ld_req_i         (ld_req),
        .ld_we_i          (ld_we),
        .ld_addr_i        (ld_addr),
        .ld_wdata_i       (ld_wdata),
        .ld_gnt_o         (ld_gnt),
        .ld_rvalid_o      (ld_rvalid),
        .ld_rdata_o       (ld_rdata),
        .err_sticky_o     (err_sticky),
        .err_addr_o       (err_addr),
        .rd_count_o       (rd_count),
        .wr_count_o       (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dm_rvalid && ld_rvalid) chk("rvalid_overlap", 32'd1, 32'd0);
            if (dm_rvalid) begin
                if (q_dm.size() == 0) begin
                    chk("dm_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    dm_exp_t e;
                    e = q_dm.pop_front();
                    chk("dm_rdata", dm_rdata, e.rdata);
                    chk("dm_err", {31'h0, dm_err}, {31'h0, e.err});
                end
            end
            if (ld_rvalid) begin
                if (q_ld.size() == 0) begin
                    chk("ld_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    chk("ld_rdata", ld_rdata, q_ld.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_op(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err);
        dm_exp_t e;
        dm_req   = 1'b1;
        dm_addr  = addr;
        dm_we    = we;
        dm_be    = be;
        dm_wdata = wd;
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        q_dm.push_back(e);
        tick();
        dm_req   = 1'b0;
    endtask

    task automatic ld_op(input logic we, input logic [11:0] idx, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, output int waited);
        bit granted = 0;
        ld_req   = 1'b1;
        ld_we    = we;
        ld_addr  = idx;
        ld_wdata = wd;
        waited   = 0;
        while (!granted && waited < 20) begin
            @(negedge clk);
            if (ld_gnt) begin
                granted = 1;
                q_ld.push_back(exp_rdata);
            end else begin
                waited++;
            end
            tick();
        end
        ld_req = 1'b0;
        if (!granted) chk("ld_grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_counts(input string tag, input logic [31:0] exp_rd, input logic [31:0] exp_wr);
        chk({tag, "_rd_count"}, rd_count, exp_rd);
        chk({tag, "_wr_count"}, wr_count, exp_wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_dm_rvalid", {31'h0, dm_rvalid}, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_dm_err", {31'h0, dm_err}, 32'h0);
        chk("rst_ld_rvalid", {31'h0, ld_rvalid}, 32'h0);
        chk("rst_ld_rdata", ld_rdata, 32'h0);
        chk("rst_err_sticky", {31'h0, err_sticky}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk_counts("rst", 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_rvalid", {30'h0, dm_rvalid, ld_rvalid}, 32'h0);
        end

        // Byte-enable store over a loader-written word
        ld_op(1'b1, 12'd0, 32'h1122_3344, 32'h0, w);
        core_op(32'h0010_0000, 1'b1, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0);
        core_op(32'h0010_0000, 1'b0, 4'b0000, 32'h0, 32'h11BB_33DD, 1'b0);
        tick();
        chk_counts("be", 32'd1, 32'd1);

        // Back-to-back store then load, both answered on consecutive cycles
        core_op(32'h0010_0004, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        chk("b2b_rvalid_n1", {31'h0, dm_rvalid}, 32'h1);
        core_op(32'h0010_0004, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        chk("b2b_rvalid_n2", {31'h0, dm_rvalid}, 32'h1);
        tick();
        chk_counts("b2b", 32'd2, 32'd2);

        // Last in-range word
        core_op(32'h0010_3FFC, 1'b1, 4'b1111, 32'h5555_AAAA, 32'h0, 1'b0);
        core_op(32'h0010_3FFC, 1'b0, 4'b0000, 32'h0, 32'h5555_AAAA, 1'b0);
        tick();
        chk_counts("top", 32'd3, 32'd3);

        // Out of range below and just above the window
        core_op(32'h000F_FFFC, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        chk("oor_sticky", {31'h0, err_sticky}, 32'h1);
        chk("oor_err_addr", err_addr, 32'h000F_FFFC);
        core_op(32'h0010_4000, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b1);
        chk("oor2_err_addr", err_addr, 32'h000F_FFFC);
        chk_counts("oor", 32'd3, 32'd3);
        core_op(32'h0010_0000, 1'b0, 4'b0000, 32'h0, 32'h11BB_33DD, 1'b0);

        // Zero byte-enable store counts but changes nothing; low address bits are ignored
        core_op(32'h0010_0000, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        core_op(32'h0010_0000, 1'b0, 4'b0000, 32'h0, 32'h11BB_33DD, 1'b0);
        core_op(32'h0010_0007, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        tick();
        chk_counts("be0", 32'd6, 32'd4);

        // Arbitration: loader waits out three core cycles
        fork
            begin
                for (int i = 0; i < 3; i++)
                    core_op(32'h0010_0004, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0);
            end
            begin
                int wait_cycles;
                ld_op(1'b0, 12'd0, 32'h0, 32'h11BB_33DD, wait_cycles);
                chk("arb_wait_cycles", wait_cycles, 32'd3);
            end
        join
        ld_op(1'b0, 12'd4095, 32'h0, 32'h5555_AAAA, w);
        chk("ld_idle_wait", w, 32'd0);
        repeat (2) tick();
        chk_counts("arb", 32'd9, 32'd4);

        // Reset mid-access: the load in flight must never be answered
        dm_req  = 1'b1;
        dm_addr = 32'h0010_0000;
        dm_we   = 1'b0;
        #2 rst_n = 1'b0;
        dm_req  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_rvalid", {31'h0, dm_rvalid}, 32'h0);
        end
        chk_counts("post_rst", 32'd0, 32'd0);
        chk("post_rst_sticky", {31'h0, err_sticky}, 32'h0);

        chk("dm_queue_drained", q_dm.size(), 32'd0);
        chk("ld_queue_drained", q_ld.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Single-port data memory responder that sits on the far end of the core's data memory interface (req/addr/we/be/wdata → rvalid/rdata) and answers every LSU access with a fixed one-cycle response. It also provides a lower-priority loader/debug port for preloading and inspecting memory, range checking with a sticky error record, and read/write access counters. It instantiates inside the SoC top next to the core and replaces the behavioural testbench memory.

## Interface
- `ADDR_BASE`, 32'h0010_0000, byte address of word 0; must be 4-byte aligned.
- `DEPTH_WORDS`, 4096, number of 32-bit words; must be a power of two, 2..65536.
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `data_mem_req_i`  in  1  core access request; accepted every cycle, no grant.
- `data_mem_addr_i`  in  32  core byte address; bits [1:0] are ignored.
- `data_mem_we_i`  in  1  1 = store, 0 = load.
- `data_mem_be_i`  in  4  byte enables for stores; bit k selects wdata[8k+7:8k].
- `data_mem_wdata_i`  in  32  store data, already lane-aligned by the LSU.
- `data_mem_rvalid_o`  out  1  response strobe, one cycle after the request.
- `data_mem_rdata_o`  out  32  load data, valid only with rvalid.
- `data_mem_err_o`  out  1  out-of-range flag for the access being answered; valid with rvalid.
- `ld_req_i`  in  1  loader request.
- `ld_we_i`  in  1  loader write; always writes the full word.
- `ld_addr_i`  in  $clog2(DEPTH_WORDS)  loader word index.
- `ld_wdata_i`  in  32  loader write data.
- `ld_gnt_o`  out  1  loader request accepted this cycle (combinational).
- `ld_rvalid_o`  out  1  loader response strobe, one cycle after grant.
- `ld_rdata_o`  out  32  loader read data.
- `err_sticky_o`  out  1  set by any core out-of-range access; cleared only by reset.
- `err_addr_o`  out  32  byte address of the first out-of-range access.
- `rd_count_o`  out  32  number of accepted in-range core loads.
- `wr_count_o`  out  32  number of accepted in-range core stores.

## Operation
- Range check: an access is in range iff `ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS`. The compare is unsigned 33-bit, so the upper bound cannot wrap. Word index = `(addr - ADDR_BASE) >> 2`.
- Arbitration: the core has absolute priority. `ld_gnt_o = ld_req_i & ~data_mem_req_i`. A loader request that is not granted holds its inputs until it is granted.
- Core store, in range: on the edge, update only the bytes whose `be` bit is 1. The following cycle drives rvalid=1, rdata=0, err=0. `wr_count` increments by 1.
- Core load, in range: the following cycle drives rvalid=1 and rdata = the full stored word (the LSU extracts bytes/halves), err=0. `rd_count` increments by 1.
- Core access out of range: the memory is not modified and counters do not change. The following cycle drives rvalid=1, rdata=32'h0, err=1. If `err_sticky` was 0, set it and capture the address into `err_addr`; later errors do not overwrite `err_addr`.
- `be`=4'b0000 store in range: no bytes change, but it still counts as a store and is still answered.
- Loader granted write: the full word is written on the edge; the next cycle drives ld_rvalid=1, ld_rdata=0. Loader granted read: the next cycle drives ld_rvalid=1 and ld_rdata = the word.
- Read-after-write: a load in cycle N+1 to the word written in cycle N returns the new data. There is no same-cycle bypass, because at most one access is accepted per cycle.
- Counters wrap from 32'hFFFF_FFFF to 0.
- Memory contents are not reset. Simulation initial contents are undefined unless preloaded through the loader port.

## Timing
- Latency is exactly 1 cycle for both ports. A back-to-back request every cycle gives rvalid every cycle; throughput is 1 access/cycle total.
- `data_mem_rvalid_o` and `ld_rvalid_o` are never both 1 in the same cycle.
- All outputs except `ld_gnt_o` are registered.
- Reset values:
  - `data_mem_rvalid_o`, `ld_rvalid_o`, `data_mem_err_o` = 0.
  - `data_mem_rdata_o`, `ld_rdata_o` = 0.
  - `err_sticky_o` = 0; `err_addr_o` = 0; both counters = 0.
- Reset asserted mid-operation: a pending response is dropped and no rvalid follows. A write sampled on the same edge that reset asserts is not guaranteed to land.
- While a response is shown, rdata holds its value until the next response. rdata is 0 after a store or error response.

## Test plan
- **Reset/idle:** assert rst_n=0 for 3 cycles, then release with no requests → all outputs 0; rvalid stays 0 for 10 cycles.
- **Byte-enable store then load:**
  - Loader writes word 0 = 32'h1122_3344.
  - Core stores addr 32'h0010_0000, be=4'b0101, wdata=32'hAABB_CCDD → rvalid next cycle.
  - Core load of the same address → rdata=32'h11BB_33DD. wr_count=1, rd_count=1.
- **Back-to-back:** core stores 32'hCAFE_F00D to 32'h0010_0004 in cycle N, loads the same address in N+1 → rvalid high in N+1 and N+2; rdata=32'hCAFE_F00D in N+2.
- **Out of range:**
  - Core load of 32'h000F_FFFC → rvalid=1, err=1, rdata=0, err_sticky=1, err_addr=32'h000F_FFFC.
  - A following store to 32'h0010_4000 (DEPTH=4096) → err=1, err_addr unchanged, memory and counters unchanged.
- **Arbitration:** hold ld_req=1 (read, index 0) while the core requests for 3 cycles → ld_gnt=0 for those cycles, =1 on the first core-idle cycle; ld_rvalid the next cycle with the correct word; never coincident with data_mem_rvalid.
- **Reset mid-access:** core load issued, rst_n dropped before the next edge → no rvalid after reset; counters are 0.
